// File: rtl/awg_sweep_ctrl_if.sv
// Host-side sweep configuration/control bundle and the sweep outputs toward the AWG.
// The master modport is the host register bank; the slave modport is the sweep controller.
interface awg_sweep_ctrl_if #(
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned DWELL_WIDTH = 24
);
  logic [PHASE_WIDTH-1:0] cfg_start_word;
  logic [PHASE_WIDTH-1:0] cfg_stop_word;
  logic [PHASE_WIDTH-1:0] cfg_step_word;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic [1:0]             cfg_mode;
  logic                   start;
  logic                   abort;
  logic [PHASE_WIDTH-1:0] Fre_word;
  logic                   step_stb;
  logic                   busy;
  logic                   done;

  modport master (
    output cfg_start_word, cfg_stop_word, cfg_step_word, cfg_dwell, cfg_mode, start, abort,
    input  Fre_word, step_stb, busy, done
  );

  modport slave (
    input  cfg_start_word, cfg_stop_word, cfg_step_word, cfg_dwell, cfg_mode, start, abort,
    output Fre_word, step_stb, busy, done
  );
endinterface

// File: rtl/awg_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the AWG tuning word from start to stop with a fixed
// dwell per point; single, repeating sawtooth and up/down triangle sweeps.
module awg_sweep_ctrl #(
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned DWELL_WIDTH = 24
) (
  input  logic            clk_in,
  input  logic            RST,
  awg_sweep_ctrl_if.slave bus
);
  localparam int unsigned PW = PHASE_WIDTH;
  localparam int unsigned DW = DWELL_WIDTH;

  // The step decision costs no cycle of its own: it is taken in the last dwell cycle
  // so that every point is held for exactly D cycles.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  start_q, stop_q, step_q;
  logic [DW-1:0]  dwell_q;
  logic [1:0]     mode_q;
  logic [PW-1:0]  fre_q, fre_d;
  logic [DW-1:0]  cnt_q, cnt_d;
  logic           dir_dn_q, dir_dn_d;
  logic           stb_q, stb_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           load_cfg;

  logic           go;
  logic           dwell_end;
  logic           single_mode;
  logic           finish;
  logic [PW:0]    up_sum;
  logic [PW:0]    dn_diff;
  logic [PW-1:0]  up_word;
  logic [PW-1:0]  dn_word;

  function automatic logic [DW-1:0] dwell_load(input logic [DW-1:0] d);
    return (d == '0) ? '0 : d - DW'(1);
  endfunction

  assign go          = bus.start && !bus.abort;
  assign dwell_end   = (cnt_q == '0);
  assign single_mode = (mode_q == 2'd0) || (mode_q == 2'd3);
  assign finish      = (start_q > stop_q) || (!dir_dn_q && (fre_q == stop_q) && single_mode);

  // Neighbouring points, computed one bit wider so the clamps see overflow and underflow.
  assign up_sum  = {1'b0, fre_q} + {1'b0, step_q};
  assign dn_diff = {1'b0, fre_q} - {1'b0, step_q};

  always_comb begin
    up_word = up_sum[PW-1:0];
    if ((step_q == '0) || (up_sum >= {1'b0, stop_q})) up_word = stop_q;
    dn_word = dn_diff[PW-1:0];
    if ((step_q == '0) || dn_diff[PW] || (dn_diff[PW-1:0] <= start_q)) dn_word = start_q;
  end

  // State register and all datapath/output registers.
  always_ff @(posedge clk_in) begin
    if (RST) begin
      state_q  <= S_IDLE;
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      mode_q   <= '0;
      fre_q    <= '0;
      cnt_q    <= '0;
      dir_dn_q <= 1'b0;
      stb_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fre_q    <= fre_d;
      cnt_q    <= cnt_d;
      dir_dn_q <= dir_dn_d;
      stb_q    <= stb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      if (load_cfg) begin
        start_q <= bus.cfg_start_word;
        stop_q  <= bus.cfg_stop_word;
        step_q  <= bus.cfg_step_word;
        dwell_q <= bus.cfg_dwell;
        mode_q  <= bus.cfg_mode;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_DWELL;
      S_DWELL: begin
        if (bus.abort)              state_d = S_IDLE;
        else if (dwell_end && finish) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, dwell counter and sweep direction.
  always_comb begin
    fre_d    = fre_q;
    cnt_d    = cnt_q;
    dir_dn_d = dir_dn_q;
    stb_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load_cfg = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (go) begin
          load_cfg = 1'b1;
          fre_d    = bus.cfg_start_word;
          cnt_d    = dwell_load(bus.cfg_dwell);
          dir_dn_d = 1'b0;
          stb_d    = 1'b1;
          busy_d   = 1'b1;
        end
      end
      S_DWELL: begin
        if (bus.abort) begin
          busy_d = 1'b0;
        end else if (!dwell_end) begin
          cnt_d = cnt_q - DW'(1);
        end else if (finish) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          stb_d = 1'b1;
          cnt_d = dwell_load(dwell_q);
          if (dir_dn_q) begin
            if (fre_q == start_q) begin
              dir_dn_d = 1'b0;
              fre_d    = up_word;
            end else begin
              fre_d    = dn_word;
            end
          end else if (fre_q == stop_q) begin
            // Only repeating modes reach here; single mode finished above.
            if (mode_q == 2'd1) begin
              fre_d = start_q;
            end else begin
              dir_dn_d = 1'b1;
              fre_d    = dn_word;
            end
          end else begin
            fre_d = up_word;
          end
        end
      end
      S_DONE:  busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  assign bus.Fre_word = fre_q;
  assign bus.step_stb = stb_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule
